// File: rtl/output_port_arbiter.sv
// Per-output-port round-robin packet arbiter with wormhole locking. The port stays locked to one
// input from the head flit until the tail flit or until FlitPerPacket flits have been transferred.
module output_port_arbiter #(
    parameter int INPUTS        = 2,
    parameter int DATA_WIDTH    = 32,
    parameter int TYPE_WIDTH    = 2,
    parameter int FlitPerPacket = 6,
    parameter int CNT_WIDTH     = $clog2(FlitPerPacket + 1)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [INPUTS-1:0]            request_bus,
    input  logic [INPUTS*DATA_WIDTH-1:0] data_in_bus,
    input  logic [INPUTS-1:0]            valid_in_bus,
    output logic [INPUTS-1:0]            ready_in_bus,
    output logic [DATA_WIDTH-1:0]        data_out,
    output logic                         valid_out,
    input  logic                         ready_out,
    output logic [INPUTS-1:0]            grant_bus,
    output logic                         busy,
    output logic                         pkt_err
);

    localparam int IDX_W = (INPUTS > 1) ? $clog2(INPUTS) : 1;
    localparam logic [TYPE_WIDTH-1:0] TYPE_HEAD     = TYPE_WIDTH'(1);
    localparam logic [TYPE_WIDTH-1:0] TYPE_TAIL     = TYPE_WIDTH'(3);
    localparam logic [TYPE_WIDTH-1:0] TYPE_HEADTAIL = TYPE_WIDTH'(0);

    typedef enum logic {IDLE, LOCKED} state_t;

    function automatic logic is_head(input logic [TYPE_WIDTH-1:0] t);
        return (t == TYPE_HEAD) || (t == TYPE_HEADTAIL);
    endfunction

    function automatic logic is_tail(input logic [TYPE_WIDTH-1:0] t);
        return (t == TYPE_TAIL) || (t == TYPE_HEADTAIL);
    endfunction

    state_t                state, state_next;
    logic [INPUTS-1:0]     grant_next;
    logic [IDX_W-1:0]      rr_ptr, rr_ptr_next;
    logic [CNT_WIDTH-1:0]  flit_cnt, flit_cnt_next;
    logic                  pkt_err_next;

    logic [INPUTS-1:0]     eligible;
    logic                  found;
    logic [IDX_W-1:0]      win;
    logic [DATA_WIDTH-1:0] sel_flit;
    logic [IDX_W-1:0]      g_idx;
    logic [TYPE_WIDTH-1:0] sel_type;
    logic [CNT_WIDTH-1:0]  cnt_inc;
    logic                  xfer;
    logic                  at_limit;
    logic                  release_pkt;

    // Only head-type flits may open a packet; stray body/tail flits wait forever in IDLE.
    always_comb begin
        eligible = '0;
        for (int i = 0; i < INPUTS; i++) begin
            eligible[i] = request_bus[i] && valid_in_bus[i] &&
                          is_head(data_in_bus[i*DATA_WIDTH + DATA_WIDTH-1 -: TYPE_WIDTH]);
        end
    end

    always_comb begin
        int idx;
        idx   = 0;
        found = 1'b0;
        win   = '0;
        for (int k = 0; k < INPUTS; k++) begin
            idx = int'(rr_ptr) + k;
            if (idx >= INPUTS) idx = idx - INPUTS;
            if (!found && eligible[idx]) begin
                found = 1'b1;
                win   = IDX_W'(idx);
            end
        end
    end

    // grant_bus is all-zero in IDLE, so the mux naturally yields zero data there.
    always_comb begin
        sel_flit = '0;
        g_idx    = '0;
        for (int i = 0; i < INPUTS; i++) begin
            if (grant_bus[i]) begin
                sel_flit = data_in_bus[i*DATA_WIDTH +: DATA_WIDTH];
                g_idx    = IDX_W'(i);
            end
        end
    end

    assign busy         = (state == LOCKED);
    assign data_out     = sel_flit;
    assign valid_out    = busy && !rst && |(valid_in_bus & grant_bus);
    assign ready_in_bus = (busy && !rst && ready_out) ? grant_bus : '0;
    assign xfer         = valid_out && ready_out;
    assign sel_type     = sel_flit[DATA_WIDTH-1 -: TYPE_WIDTH];
    assign cnt_inc      = flit_cnt + CNT_WIDTH'(1);
    assign at_limit     = (cnt_inc == CNT_WIDTH'(FlitPerPacket));
    assign release_pkt  = xfer && (is_tail(sel_type) || at_limit);

    always_comb begin
        state_next    = state;
        grant_next    = grant_bus;
        rr_ptr_next   = rr_ptr;
        flit_cnt_next = flit_cnt;
        pkt_err_next  = pkt_err;
        case (state)
            IDLE: begin
                if (found) begin
                    state_next    = LOCKED;
                    grant_next    = INPUTS'(1) << win;
                    flit_cnt_next = '0;
                end
            end
            LOCKED: begin
                if (xfer) begin
                    flit_cnt_next = cnt_inc;
                    if (is_head(sel_type) && (flit_cnt != '0)) pkt_err_next = 1'b1;
                end
                if (release_pkt) begin
                    state_next    = IDLE;
                    grant_next    = '0;
                    flit_cnt_next = '0;
                    rr_ptr_next   = (g_idx == IDX_W'(INPUTS-1)) ? '0 : g_idx + IDX_W'(1);
                    if (!is_tail(sel_type)) pkt_err_next = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            grant_bus <= '0;
            rr_ptr    <= '0;
            flit_cnt  <= '0;
            pkt_err   <= 1'b0;
        end else begin
            state     <= state_next;
            grant_bus <= grant_next;
            rr_ptr    <= rr_ptr_next;
            flit_cnt  <= flit_cnt_next;
            pkt_err   <= pkt_err_next;
        end
    end

endmodule

// File: tb/tb_output_port_arbiter.sv
// Directed bench for output_port_arbiter: a cycle table on a 2-input instance plus hand-written
// sequences for mid-packet head errors and reset/round-robin wrap on a 4-input instance.
module tb_output_port_arbiter;

    localparam logic [1:0] H  = 2'b01;
    localparam logic [1:0] B  = 2'b10;
    localparam logic [1:0] T  = 2'b11;
    localparam logic [1:0] HT = 2'b00;

    logic clk;
    int   n_tests = 0;
    int   n_fail  = 0;

    // 2-input instance
    logic        rst;
    logic [1:0]  req, vin, rin, gnt;
    logic [63:0] din;
    logic [31:0] dout;
    logic        vout, rdy, busy, err;

    // 4-input instance
    logic         rst4;
    logic [3:0]   req4, vin4, rin4, gnt4;
    logic [127:0] din4;
    logic [31:0]  dout4;
    logic         vout4, rdy4, busy4, err4;

    output_port_arbiter #(.INPUTS(2)) dut (
        .clk(clk), .rst(rst), .request_bus(req), .data_in_bus(din), .valid_in_bus(vin),
        .ready_in_bus(rin), .data_out(dout), .valid_out(vout), .ready_out(rdy),
        .grant_bus(gnt), .busy(busy), .pkt_err(err)
    );

    output_port_arbiter #(.INPUTS(4)) dut4 (
        .clk(clk), .rst(rst4), .request_bus(req4), .data_in_bus(din4), .valid_in_bus(vin4),
        .ready_in_bus(rin4), .data_out(dout4), .valid_out(vout4), .ready_out(rdy4),
        .grant_bus(gnt4), .busy(busy4), .pkt_err(err4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] req;
        logic [1:0] vin;
        logic [1:0] t0;
        logic [1:0] t1;
        logic       rdy;
        logic [1:0] e_gnt;
        logic       e_busy;
        logic       e_vout;
        logic [1:0] e_rin;
        int         e_dsel;
        logic       e_err;
    } vec_t;

    vec_t vt[$];

    function automatic vec_t mk(input logic [1:0] rq, vi, a0, a1, input logic rd,
                                input logic [1:0] g, input logic bs, vo, input logic [1:0] ri,
                                input int ds, input logic er);
        vec_t v;
        v.req = rq; v.vin = vi; v.t0 = a0; v.t1 = a1; v.rdy = rd;
        v.e_gnt = g; v.e_busy = bs; v.e_vout = vo; v.e_rin = ri; v.e_dsel = ds; v.e_err = er;
        return v;
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic drive2(input logic r, input logic [1:0] rq, vi, a0, a1, input logic rd);
        @(negedge clk);
        rst = r; req = rq; vin = vi; rdy = rd;
        din = {a1, 6'd1, 24'h00abcd, a0, 6'd0, 24'h00abcd};
        #1;
    endtask

    task automatic drive4(input logic r, input logic [3:0] rq, input logic [1:0] a1, a3);
        @(negedge clk);
        rst4 = r; req4 = rq; vin4 = rq; rdy4 = 1'b1;
        din4 = {a3, 6'd3, 24'h333333, B, 6'd2, 24'h222222, a1, 6'd1, 24'h111111, B, 6'd0, 24'h000000};
        #1;
    endtask

    task automatic chk4(input string tag, input logic [3:0] g, input logic bs, vo,
                        input logic [3:0] ri, input logic [31:0] d);
        chk({tag, " grant"}, gnt4, g);
        chk({tag, " busy"}, busy4, bs);
        chk({tag, " valid_out"}, vout4, vo);
        chk({tag, " ready_in"}, rin4, ri);
        chk({tag, " data_out"}, dout4, d);
    endtask

    initial begin
        logic [31:0] exp_d;

        // contention from rr_ptr=0: input 0, bubble, input 1, bubble, input 0 (HEADTAIL)
        vt.push_back(mk(2'b11, 2'b11, H,  H,  1, 2'b00, 0, 0, 2'b00, 0, 0));
        vt.push_back(mk(2'b11, 2'b11, H,  H,  1, 2'b01, 1, 1, 2'b01, 1, 0));
        vt.push_back(mk(2'b11, 2'b11, T,  H,  1, 2'b01, 1, 1, 2'b01, 1, 0));
        vt.push_back(mk(2'b11, 2'b11, H,  H,  1, 2'b00, 0, 0, 2'b00, 0, 0));
        vt.push_back(mk(2'b11, 2'b11, H,  H,  1, 2'b10, 1, 1, 2'b10, 2, 0));
        vt.push_back(mk(2'b11, 2'b11, H,  T,  1, 2'b10, 1, 1, 2'b10, 2, 0));
        vt.push_back(mk(2'b11, 2'b11, H,  H,  1, 2'b00, 0, 0, 2'b00, 0, 0));
        vt.push_back(mk(2'b11, 2'b11, HT, H,  1, 2'b01, 1, 1, 2'b01, 1, 0));
        vt.push_back(mk(2'b00, 2'b00, H,  H,  1, 2'b00, 0, 0, 2'b00, 0, 0));
        // 6-flit packet on input 0 with a 3-cycle ready stall and one valid gap
        vt.push_back(mk(2'b01, 2'b01, H,  B,  1, 2'b00, 0, 0, 2'b00, 0, 0));
        vt.push_back(mk(2'b01, 2'b01, H,  B,  1, 2'b01, 1, 1, 2'b01, 1, 0));
        vt.push_back(mk(2'b01, 2'b01, B,  B,  1, 2'b01, 1, 1, 2'b01, 1, 0));
        vt.push_back(mk(2'b01, 2'b01, B,  B,  0, 2'b01, 1, 1, 2'b00, 1, 0));
        vt.push_back(mk(2'b01, 2'b01, B,  B,  0, 2'b01, 1, 1, 2'b00, 1, 0));
        vt.push_back(mk(2'b01, 2'b01, B,  B,  0, 2'b01, 1, 1, 2'b00, 1, 0));
        vt.push_back(mk(2'b01, 2'b01, B,  B,  1, 2'b01, 1, 1, 2'b01, 1, 0));
        vt.push_back(mk(2'b01, 2'b01, B,  B,  1, 2'b01, 1, 1, 2'b01, 1, 0));
        vt.push_back(mk(2'b01, 2'b00, B,  B,  1, 2'b01, 1, 0, 2'b01, 1, 0));
        vt.push_back(mk(2'b01, 2'b01, B,  B,  1, 2'b01, 1, 1, 2'b01, 1, 0));
        vt.push_back(mk(2'b01, 2'b01, T,  B,  1, 2'b01, 1, 1, 2'b01, 1, 0));
        vt.push_back(mk(2'b00, 2'b00, B,  B,  1, 2'b00, 0, 0, 2'b00, 0, 0));
        // early tail on input 1 (H,B,T), then stray body flits stay ineligible
        vt.push_back(mk(2'b10, 2'b10, B,  H,  1, 2'b00, 0, 0, 2'b00, 0, 0));
        vt.push_back(mk(2'b10, 2'b10, B,  H,  1, 2'b10, 1, 1, 2'b10, 2, 0));
        vt.push_back(mk(2'b10, 2'b10, B,  B,  1, 2'b10, 1, 1, 2'b10, 2, 0));
        vt.push_back(mk(2'b10, 2'b10, B,  T,  1, 2'b10, 1, 1, 2'b10, 2, 0));
        vt.push_back(mk(2'b10, 2'b10, B,  B,  1, 2'b00, 0, 0, 2'b00, 0, 0));
        vt.push_back(mk(2'b10, 2'b10, B,  B,  1, 2'b00, 0, 0, 2'b00, 0, 0));
        // six flits without a tail: forced release and sticky error
        vt.push_back(mk(2'b01, 2'b01, H,  B,  1, 2'b00, 0, 0, 2'b00, 0, 0));
        vt.push_back(mk(2'b01, 2'b01, H,  B,  1, 2'b01, 1, 1, 2'b01, 1, 0));
        vt.push_back(mk(2'b01, 2'b01, B,  B,  1, 2'b01, 1, 1, 2'b01, 1, 0));
        vt.push_back(mk(2'b01, 2'b01, B,  B,  1, 2'b01, 1, 1, 2'b01, 1, 0));
        vt.push_back(mk(2'b01, 2'b01, B,  B,  1, 2'b01, 1, 1, 2'b01, 1, 0));
        vt.push_back(mk(2'b01, 2'b01, B,  B,  1, 2'b01, 1, 1, 2'b01, 1, 0));
        vt.push_back(mk(2'b01, 2'b01, B,  B,  1, 2'b01, 1, 1, 2'b01, 1, 0));
        vt.push_back(mk(2'b00, 2'b00, B,  B,  1, 2'b00, 0, 0, 2'b00, 0, 1));
        vt.push_back(mk(2'b11, 2'b11, H,  H,  1, 2'b00, 0, 0, 2'b00, 0, 1));
        vt.push_back(mk(2'b11, 2'b11, H,  HT, 1, 2'b10, 1, 1, 2'b10, 2, 1));
        vt.push_back(mk(2'b00, 2'b00, H,  H,  1, 2'b00, 0, 0, 2'b00, 0, 1));

        rst = 1'b1; req = '0; vin = '0; rdy = 1'b1; din = '0;
        rst4 = 1'b1; req4 = '0; vin4 = '0; rdy4 = 1'b1; din4 = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0; rst4 = 1'b0;
        @(negedge clk);
        #1;
        chk("reset grant", gnt, 2'b00);
        chk("reset busy", busy, 1'b0);
        chk("reset pkt_err", err, 1'b0);
        chk("reset valid_out", vout, 1'b0);
        chk("reset ready_in", rin, 2'b00);
        chk("reset data_out", dout, 32'h0);

        for (int i = 0; i < vt.size(); i++) begin
            @(negedge clk);
            req = vt[i].req; vin = vt[i].vin; rdy = vt[i].rdy;
            din = {vt[i].t1, 6'd1, 24'(i), vt[i].t0, 6'd0, 24'(i)};
            #1;
            case (vt[i].e_dsel)
                1:       exp_d = {vt[i].t0, 6'd0, 24'(i)};
                2:       exp_d = {vt[i].t1, 6'd1, 24'(i)};
                default: exp_d = 32'h0;
            endcase
            chk($sformatf("v%0d grant", i), gnt, vt[i].e_gnt);
            chk($sformatf("v%0d busy", i), busy, vt[i].e_busy);
            chk($sformatf("v%0d valid_out", i), vout, vt[i].e_vout);
            chk($sformatf("v%0d ready_in", i), rin, vt[i].e_rin);
            chk($sformatf("v%0d data_out", i), dout, exp_d);
            chk($sformatf("v%0d pkt_err", i), err, vt[i].e_err);
        end

        // reset clears the sticky error; then a HEAD arriving mid-packet sets it again
        drive2(1, 2'b00, 2'b00, B, B, 1);
        drive2(0, 2'b01, 2'b01, H, B, 1);
        chk("hd reset pkt_err", err, 1'b0);
        chk("hd idle grant", gnt, 2'b00);
        drive2(0, 2'b01, 2'b01, H, B, 1);
        chk("hd first busy", busy, 1'b1);
        drive2(0, 2'b01, 2'b01, H, B, 1);
        chk("hd before err", err, 1'b0);
        drive2(0, 2'b01, 2'b01, T, B, 1);
        chk("hd err set", err, 1'b1);
        chk("hd still locked", gnt, 2'b01);
        drive2(0, 2'b00, 2'b00, B, B, 1);
        chk("hd released", busy, 1'b0);
        chk("hd err sticky", err, 1'b1);

        // 4 inputs, 1 and 3 requesting: grant 1, then 3, reset mid-packet, pointer back to 0
        drive4(0, 4'b1010, H, H);
        chk4("q1", 4'b0000, 0, 0, 4'b0000, 32'h0);
        drive4(0, 4'b1010, HT, H);
        chk4("q2", 4'b0010, 1, 1, 4'b0010, {HT, 6'd1, 24'h111111});
        drive4(0, 4'b1010, H, H);
        chk4("q3", 4'b0000, 0, 0, 4'b0000, 32'h0);
        drive4(0, 4'b1010, H, H);
        chk4("q4", 4'b1000, 1, 1, 4'b1000, {H, 6'd3, 24'h333333});
        drive4(0, 4'b1010, H, B);
        chk4("q5", 4'b1000, 1, 1, 4'b1000, {B, 6'd3, 24'h333333});
        drive4(1, 4'b1010, H, B);
        chk("q6 ready_in in reset", rin4, 4'b0000);
        chk("q6 valid_out in reset", vout4, 1'b0);
        drive4(0, 4'b1010, H, H);
        chk4("q7", 4'b0000, 0, 0, 4'b0000, 32'h0);
        chk("q7 pkt_err", err4, 1'b0);
        drive4(0, 4'b1010, HT, H);
        chk4("q8", 4'b0010, 1, 1, 4'b0010, {HT, 6'd1, 24'h111111});
        drive4(0, 4'b1010, H, H);
        chk4("q9", 4'b0000, 0, 0, 4'b0000, 32'h0);
        drive4(0, 4'b1010, H, HT);
        chk4("q10", 4'b1000, 1, 1, 4'b1000, {HT, 6'd3, 24'h333333});
        drive4(0, 4'b1010, H, H);
        chk4("q11", 4'b0000, 0, 0, 4'b0000, 32'h0);
        drive4(0, 4'b1010, H, H);
        chk4("q12", 4'b0010, 1, 1, 4'b0010, {H, 6'd1, 24'h111111});
        chk("q12 pkt_err", err4, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
